branch_predictor: RTL and testbench
===================================

# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters and optional return address stack. Serves same-cycle predictions to the fetch stage and consumes the `verify_result_t` bus driven by the execute stage. It trains the tables once per resolved branch and issues a registered one-cycle redirect on misprediction. It is the receiving end of the execute-to-BPU verify interface.

## Interface
- `ENTRIES`, 64: BTB entries; a power of two, at least 4. `IW = $clog2(ENTRIES)`.
- `RAS_DEPTH`, 8: return stack entries; a power of two. Used only with `BPU_RAS_EN`.
- `clk` in 1: clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `fs_pc` in 32: fetch PC to predict.
- `fs_predict` out `predict_t`: `{is_taken, target[31:0], entry[IW-1:0]}`. Combinational from `fs_pc` and the table flops.
- `es_to_bpu_bus` in `verify_result_t`: `{br_type[2:0], ready, predict_entry, pc, predict_sucess, is_taken, correct_target}`.
- `pipeline_flush` in `pipeline_flush_t`: only `.flush` is used.
- `bpu_redirect` out `redirect_t`: `{valid, target[31:0]}`. Registered.

## Operation
- `br_type` encoding: NONE=0, COND=1, JUMP=2 (direct), CALL=3, RET=4, IND=5 (indirect non-return); 6 and 7 are treated as NONE.
- Entry fields: `valid`, `tag = pc[31:IW+2]`, `target[31:0]`, `type[2:0]`, `ctr[1:0]`.
- Lookup:
  - Index is `fs_pc[IW+1:2]`. `hit = valid && tag == fs_pc[31:IW+2]`.
  - `is_taken = hit && (type != COND || ctr[1])`.
  - `target` is the entry target, or the RAS top for RET (see Configuration).
  - `entry` is always the index.
  - On a miss, `is_taken = 0` and `target = fs_pc + 8`.
- Update acceptance: `accept = ready && br_type in 1..5 && !(upd_done && pc == last_pc)`.
  - On accept: `upd_done <= 1` and `last_pc <= pc`.
  - Any cycle with `br_type == NONE` clears `upd_done`.
  - This prevents double training while execute is stalled with `ready` held high.
- Training on accept, with index `predict_entry` and tag from `pc`:
  - Hit: `ctr` saturating increments if `is_taken`, else decrements (3 and 0 hold). If `is_taken`, `target <= correct_target` and `type <= br_type`.
  - Miss and `is_taken`: allocate and overwrite with `valid=1`, new tag, `target=correct_target`, `type=br_type`, `ctr=2'b10`.
  - Miss and not taken: no write.
- Redirect:
  - Condition: `accept && !predict_sucess && !pipeline_flush.flush`.
  - Effect: next cycle `bpu_redirect = {1, correct_target}`.
  - Otherwise `valid <= 0`. The redirect target register holds its value when `valid` is low.
- A flush on the redirect cycle itself does not cancel an already-registered redirect. The consumer gives flush priority.

## Timing
- Prediction: 0-cycle combinational. It reflects table state at the start of the cycle; a same-cycle update to the same index is not bypassed.
- Training: table writes become visible to lookups in the cycle after accept.
- Redirect: asserted in the cycle after accept, for exactly one cycle.
- Reset, including reset arriving mid-operation:
  - All `valid` and `ctr` bits clear, and `upd_done` clears.
  - RAS pointer and count go to 0.
  - `bpu_redirect` is 0. Table `target`, `tag` and `type` bits are don't-care.
  - Any update presented in the reset cycle is dropped.
- At most one update is accepted per cycle.

## Configuration
- Macro: `BPU_RAS_EN`.
- Defined:
  - A `RAS_DEPTH`-entry circular stack with a pointer and a saturating count (0..`RAS_DEPTH`).
  - Accepted CALL with `is_taken`: push `pc + 8`. On overflow the pointer wraps, the oldest entry is overwritten, and count stays at `RAS_DEPTH`.
  - Accepted RET: pop. On an empty stack, no pointer change.
  - Lookup of a hit RET entry with count > 0 predicts the RAS top; with count == 0 it falls back to the BTB target.
- Undefined: no stack is built, and RET is predicted from the BTB target like IND.

## Structure
- Shared package `cpu.svh`:
  - Types `predict_t` and `redirect_t`, and the existing `verify_result_t`.
  - Enum `br_type_t` with the values above.
  - Constant `BPU_CTR_INIT = 2'b10`.
- One sub-module, `bpu_ras`: the stack, with push/pop/top/empty. Instantiated only under `BPU_RAS_EN`.
- The BTB array lives in a flop array in `branch_predictor`.

## Test plan
- Reset then lookup:
  - Stimulus: after reset, `fs_pc = 0xBFC00000`.
  - Required: `is_taken = 0`, `target = 0xBFC00008`, `bpu_redirect.valid = 0`.
- COND allocate and train:
  - Stimulus: verify `pc = 0x80000100`, taken, `correct_target = 0x80000040`, `predict_sucess = 0`.
  - Required: next cycle `redirect = {1, 0x80000040}`. Lookup of 0x80000100 then gives taken with target 0x80000040 and `ctr = 2`.
  - Stimulus: two not-taken verifies.
  - Required: `ctr = 0`, not taken.
- Stall dedupe:
  - Stimulus: hold the same taken COND verify with `ready = 1` for 5 cycles.
  - Required: `ctr` moves once (2 to 3) and at most one redirect pulse.
- Alias eviction:
  - Stimulus: taken verify at 0x80000100, then one at `0x80000100 + 4*ENTRIES`.
  - Required: the first PC misses and the second hits.
- Flush suppression:
  - Stimulus: mispredicted verify in the same cycle as `pipeline_flush.flush = 1`.
  - Required: no redirect and the table is still trained.
- RAS (with `BPU_RAS_EN`):
  - Stimulus: 9 CALLs from 0x80001000 + 16k, k = 0..8, with `RAS_DEPTH = 8`. Then a RET, with its BTB entry trained beforehand.
  - Required: the RET predicts 0x80001088. After 8 more pops, the RET predicts its BTB target.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared front-end types for the branch predictor and the execute-to-BPU verify bus.
// Index fields are BPU_IDX_W wide so the bus layout does not depend on the BTB size.
package branch_predictor_pkg;

    localparam int         BPU_IDX_W    = 16;
    localparam logic [1:0] BPU_CTR_INIT = 2'b10;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_COND = 3'd1,
        BR_JUMP = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4,
        BR_IND  = 3'd5
    } br_type_t;

    typedef struct packed {
        logic                 is_taken;
        logic [31:0]          target;
        logic [BPU_IDX_W-1:0] entry;
    } predict_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
    } redirect_t;

    typedef struct packed {
        logic [2:0]           br_type;
        logic                 ready;
        logic [BPU_IDX_W-1:0] predict_entry;
        logic [31:0]          pc;
        logic                 predict_sucess;
        logic                 is_taken;
        logic [31:0]          correct_target;
    } verify_result_t;

    typedef struct packed {
        logic flush;
    } pipeline_flush_t;

    // Encodings 6 and 7 are reserved and behave like BR_NONE.
    function automatic logic is_branch(input logic [2:0] t);
        return (t >= 3'd1) && (t <= 3'd5);
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Circular return address stack for branch_predictor; built only when BPU_RAS_EN is defined.
// Overflow overwrites the oldest entry; popping an empty stack leaves it unchanged.
`ifdef BPU_RAS_EN
module bpu_ras #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   stack_q [DEPTH];
    logic [31:0]   stack_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] top_ptr;

    always_comb begin
        stack_d = stack_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            stack_d[ptr_q] = push_addr;
            ptr_d          = ptr_q + PW'(1);
            if (count_q != CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (pop && (count_q != '0)) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    // ptr points at the next free slot, so the top sits one below it.
    assign top_ptr = ptr_q - PW'(1);
    assign top     = stack_q[top_ptr];
    assign empty   = (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

endmodule
`endif

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, trained from the execute verify bus.
// Define BPU_RAS_EN to predict returns from a return address stack (bpu_ras).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     fs_pc,
    output predict_t        fs_predict,
    input  verify_result_t  es_to_bpu_bus,
    input  pipeline_flush_t pipeline_flush,
    output redirect_t       bpu_redirect
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [TW-1:0]      tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [2:0]         type_q   [ENTRIES];
    logic [2:0]         type_d   [ENTRIES];

    logic        upd_done_q, upd_done_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_target_q, redir_target_d;

    logic [IW-1:0] lk_idx;
    logic          lk_hit;
    logic [31:0]   lk_tgt;

    logic          up_branch;
    logic          accept;
    logic [IW-1:0] up_idx;
    logic [TW-1:0] up_tag;
    logic          up_hit;
    logic          unused_entry_hi;

    assign lk_idx = fs_pc[IW+1:2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == fs_pc[31:IW+2]);

    always_comb begin
        fs_predict          = '0;
        fs_predict.entry    = BPU_IDX_W'(lk_idx);
        fs_predict.is_taken = lk_hit && ((type_q[lk_idx] != BR_COND) || ctr_q[lk_idx][1]);
        fs_predict.target   = lk_hit ? lk_tgt : fs_pc + 32'd8;
    end

`ifdef BPU_RAS_EN
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_push;
    logic        ras_pop;

    assign ras_push = accept && (es_to_bpu_bus.br_type == BR_CALL) && es_to_bpu_bus.is_taken;
    assign ras_pop  = accept && (es_to_bpu_bus.br_type == BR_RET);

    bpu_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_addr(es_to_bpu_bus.pc + 32'd8),
        .top      (ras_top),
        .empty    (ras_empty)
    );

    // An empty stack falls back to whatever target the BTB last learned.
    assign lk_tgt = ((type_q[lk_idx] == BR_RET) && !ras_empty) ? ras_top : target_q[lk_idx];
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    assign lk_tgt = target_q[lk_idx];
`endif

    // A stalled execute stage holds ready high; train only once per distinct branch.
    assign up_branch       = is_branch(es_to_bpu_bus.br_type);
    assign accept          = es_to_bpu_bus.ready && up_branch &&
                             !(upd_done_q && (es_to_bpu_bus.pc == last_pc_q));
    assign up_idx          = es_to_bpu_bus.predict_entry[IW-1:0];
    assign up_tag          = es_to_bpu_bus.pc[31:IW+2];
    assign up_hit          = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign unused_entry_hi = ^es_to_bpu_bus.predict_entry[BPU_IDX_W-1:IW];

    always_comb begin
        valid_d    = valid_q;
        ctr_d      = ctr_q;
        tag_d      = tag_q;
        target_d   = target_q;
        type_d     = type_q;
        upd_done_d = upd_done_q;
        last_pc_d  = last_pc_q;

        if (!up_branch) begin
            upd_done_d = 1'b0;
        end
        if (accept) begin
            upd_done_d = 1'b1;
            last_pc_d  = es_to_bpu_bus.pc;
            if (up_hit) begin
                ctr_d[up_idx] = ctr_step(ctr_q[up_idx], es_to_bpu_bus.is_taken);
                if (es_to_bpu_bus.is_taken) begin
                    target_d[up_idx] = es_to_bpu_bus.correct_target;
                    type_d[up_idx]   = es_to_bpu_bus.br_type;
                end
            end else if (es_to_bpu_bus.is_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = es_to_bpu_bus.correct_target;
                type_d[up_idx]   = es_to_bpu_bus.br_type;
                ctr_d[up_idx]    = BPU_CTR_INIT;
            end
        end
    end

    always_comb begin
        redir_valid_d  = accept && !es_to_bpu_bus.predict_sucess && !pipeline_flush.flush;
        redir_target_d = redir_valid_d ? es_to_bpu_bus.correct_target : redir_target_q;
    end

    assign bpu_redirect.valid  = redir_valid_q;
    assign bpu_redirect.target = redir_target_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b00;
            end
            upd_done_q     <= 1'b0;
            redir_valid_q  <= 1'b0;
            redir_target_q <= '0;
        end else begin
            valid_q        <= valid_d;
            ctr_q          <= ctr_d;
            upd_done_q     <= upd_done_d;
            redir_valid_q  <= redir_valid_d;
            redir_target_q <= redir_target_d;
        end
    end

    // Payload fields are qualified by valid/upd_done, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q     <= tag_d;
        target_q  <= target_d;
        type_q    <= type_d;
        last_pc_q <= last_pc_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a behavioural table/stack model.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int ENTRIES   = 64;
    localparam int RAS_DEPTH = 8;
    localparam int IW        = 6;
`ifdef BPU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     fs_pc;
    predict_t        fs_predict;
    verify_result_t  bus;
    pipeline_flush_t flush;
    redirect_t       bpu_redirect;

    int errors = 0;
    int checks = 0;

    // Behavioural model: one record per BTB slot plus a list-based return stack.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    bit [31:0]   m_tgt   [ENTRIES];
    int          m_type  [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_done;
    bit [31:0]   m_last;
    bit          m_rv;
    bit [31:0]   m_rt;
    bit [31:0]   m_ras [$];

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES  (ENTRIES),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fs_pc         (fs_pc),
        .fs_predict    (fs_predict),
        .es_to_bpu_bus (bus),
        .pipeline_flush(flush),
        .bpu_redirect  (bpu_redirect)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int  t;
        int  i;
        bit  legal;
        bit  acc;
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 0;
            end
            m_done = 1'b0;
            m_rv   = 1'b0;
            m_rt   = '0;
            m_ras.delete();
            return;
        end
        t     = int'(bus.br_type);
        legal = (t >= 1) && (t <= 5);
        acc   = bus.ready && legal && !(m_done && (bus.pc == m_last));
        if (acc && !bus.predict_sucess && !flush.flush) begin
            m_rv = 1'b1;
            m_rt = bus.correct_target;
        end else begin
            m_rv = 1'b0;
        end
        if (!legal) m_done = 1'b0;
        if (acc) begin
            m_done = 1'b1;
            m_last = bus.pc;
            i = int'(bus.predict_entry) % ENTRIES;
            if (m_valid[i] && (m_tag[i] == (bus.pc >> (IW + 2)))) begin
                if (bus.is_taken) begin
                    m_ctr[i]  = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i]  = bus.correct_target;
                    m_type[i] = t;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (bus.is_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = bus.pc >> (IW + 2);
                m_tgt[i]   = bus.correct_target;
                m_type[i]  = t;
                m_ctr[i]   = 2;
            end
            if (RAS_ON) begin
                if (t == 3 && bus.is_taken) begin
                    m_ras.push_back(bus.pc + 32'd8);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end
                if (t == 4 && m_ras.size() > 0) void'(m_ras.pop_back());
            end
        end
    endtask

    function automatic void m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
        int i;
        bit hit;
        i   = int'((pc >> 2) % ENTRIES);
        hit = m_valid[i] && (m_tag[i] == (pc >> (IW + 2)));
        tk  = hit && ((m_type[i] != 1) || (m_ctr[i] >= 2));
        if (!hit) tg = pc + 32'd8;
        else if (RAS_ON && m_type[i] == 4 && m_ras.size() > 0) tg = m_ras[m_ras.size() - 1];
        else tg = m_tgt[i];
    endfunction

    task automatic cycle();
        redirect_t e;
        @(posedge clk);
        model_edge();
        #1;
        e.valid  = m_rv;
        e.target = m_rt;
        chk("redirect", bpu_redirect, e);
    endtask

    task automatic idle();
        bus.br_type = 3'd0;
        bus.ready   = 1'b0;
        flush.flush = 1'b0;
    endtask

    task automatic drive(input bit [31:0] pc, input int t, input bit tk, input bit [31:0] tgt,
                         input bit succ, input bit fl);
        bus.br_type        = 3'(t);
        bus.ready          = 1'b1;
        bus.pc             = pc;
        bus.predict_entry  = 16'((pc >> 2) % ENTRIES);
        bus.predict_sucess = succ;
        bus.is_taken       = tk;
        bus.correct_target = tgt;
        flush.flush        = fl;
    endtask

    task automatic verify(input bit [31:0] pc, input int t, input bit tk, input bit [31:0] tgt,
                          input bit succ);
        drive(pc, t, tk, tgt, succ, 1'b0);
        cycle();
        idle();
        cycle();
    endtask

    task automatic look(input string tag, input bit [31:0] pc, input bit tk, input bit [31:0] tg);
        fs_pc = pc;
        #1;
        chk({tag, ".taken"}, fs_predict.is_taken, tk);
        chk({tag, ".target"}, fs_predict.target, tg);
        chk({tag, ".entry"}, fs_predict.entry, (pc >> 2) % ENTRIES);
    endtask

    initial begin
        int        pulses;
        bit        tk;
        bit [31:0] tg;
        bit [31:0] pc;

        bus   = '0;
        flush = '0;
        fs_pc = 32'hBFC0_0000;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        look("reset_lookup", 32'hBFC0_0000, 1'b0, 32'hBFC0_0008);
        chk("reset_redirect", bpu_redirect, 33'h0);

        // COND allocate, redirect and train down
        drive(32'h8000_0100, 1, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        cycle();
        chk("cond_redirect", bpu_redirect, {1'b1, 32'h8000_0040});
        idle();
        cycle();
        chk("cond_redirect_drop", bpu_redirect.valid, 1'b0);
        look("cond_hit", 32'h8000_0100, 1'b1, 32'h8000_0040);
        verify(32'h8000_0100, 1, 1'b0, 32'h8000_0104, 1'b1);
        look("cond_nt1", 32'h8000_0100, 1'b0, 32'h8000_0040);
        verify(32'h8000_0100, 1, 1'b0, 32'h8000_0104, 1'b1);
        look("cond_nt2", 32'h8000_0100, 1'b0, 32'h8000_0040);

        // Stall dedupe: counter 0 -> 1 only, a single redirect pulse
        pulses = 0;
        drive(32'h8000_0100, 1, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (bpu_redirect.valid) pulses++;
        end
        idle();
        cycle();
        chk("stall_pulses", pulses, 1);
        look("stall_ctr1", 32'h8000_0100, 1'b0, 32'h8000_0040);
        verify(32'h8000_0100, 1, 1'b1, 32'h8000_0040, 1'b1);
        look("stall_ctr2", 32'h8000_0100, 1'b1, 32'h8000_0040);

        // Alias eviction
        verify(32'h8000_0200, 1, 1'b1, 32'h8000_0500, 1'b1);
        look("alias_old", 32'h8000_0100, 1'b0, 32'h8000_0108);
        look("alias_new", 32'h8000_0200, 1'b1, 32'h8000_0500);

        // Flush suppresses the redirect but not the training
        drive(32'h8000_0308, 2, 1'b1, 32'h8000_0600, 1'b0, 1'b1);
        cycle();
        chk("flush_no_redirect", bpu_redirect.valid, 1'b0);
        idle();
        cycle();
        look("flush_trained", 32'h8000_0308, 1'b1, 32'h8000_0600);

`ifdef BPU_RAS_EN
        verify(32'h8000_2004, 4, 1'b1, 32'h8000_3000, 1'b1);
        for (int k = 0; k < 9; k++) begin
            verify(32'h8000_1000 + 32'(16 * k), 3, 1'b1, 32'h8000_4000, 1'b1);
        end
        look("ras_top", 32'h8000_2004, 1'b1, 32'h8000_1088);
        for (int k = 0; k < 8; k++) begin
            verify(32'h8000_2004, 4, 1'b1, 32'h8000_3000, 1'b1);
        end
        look("ras_empty", 32'h8000_2004, 1'b1, 32'h8000_3000);
`endif

        // Randomized traffic, including a held bus and a mid-run reset
        for (int n = 0; n < 400; n++) begin
            reset = (n == 200);
            if ($urandom_range(0, 3) != 0) begin
                pc = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7)) + 32'(256 * $urandom_range(0, 1));
                drive(pc, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      32'h8001_0000 + 32'(4 * $urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
                bus.ready = ($urandom_range(0, 3) != 0);
            end
            cycle();
            pc = 32'h8000_0000 + 32'(4 * $urandom_range(0, 7)) + 32'(256 * $urandom_range(0, 1));
            m_predict(pc, tk, tg);
            look("rand", pc, tk, tg);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
